alu_muldiv: RTL

ALU_MULDIV -- requirements
Module: alu_muldiv

---
 rtl/muldiv_pkg.sv | 37 +++
 rtl/muldiv_div_step.sv | 28 ++
 rtl/alu_muldiv.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// The divider is built only when ALU_MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned WLEN = 32;

    // RV64M funct3 encodings
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    // Most-negative dividends: full width, and word width after sign extension
    localparam logic [XLEN-1:0] XMIN     = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] WMIN_EXT = 64'hFFFF_FFFF_8000_0000;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic [XLEN-1:0] sext32(input logic [WLEN-1:0] v);
        return {{(XLEN-WLEN){v[WLEN-1]}}, v};
    endfunction

    // Conditional two's-complement negation
    function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + 64'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
// Only compiled when ALU_MULDIV_DIV_EN is defined.
`ifdef ALU_MULDIV_DIV_EN
module muldiv_div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic            dividend_msb_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_bit_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Trial subtract; a clear sign bit means the divisor fits.
    // Partial remainder is always below the divisor, so 65 bits cannot overflow.
    always_comb begin
        shifted = {rem_i, dividend_msb_i};
        diff    = shifted - {1'b0, divisor_i};
        q_bit_o = ~diff[XLEN];
        rem_o   = q_bit_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

endmodule
`endif

// File: rtl/alu_muldiv.sv
// Iterative RV64M multiply/divide unit: one shift-add or restoring-subtract
// step per cycle, 64 steps (32 for word ops), with single-cycle handling of
// divide-by-zero and signed overflow.
// Build option: ALU_MULDIV_DIV_EN enables the divider; without it divide ops
// complete immediately with result 0 and out_illegal set.
module alu_muldiv
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            is_w,
    input  logic [XLEN-1:0] alu_a,
    input  logic [XLEN-1:0] alu_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_illegal
);

    state_t            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              illegal_q, illegal_d;

    // Captured request
    logic [2:0]        op_q;
    logic              w_q;
    logic              neg_q;

    // Multiplier datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
    logic [2*XLEN-1:0] acc_q, mcand_q;
    logic [XLEN-1:0]   mplier_q;

    logic              accept;
    logic              w_in;
    logic              a_neg_mul, b_neg_mul;
    logic [XLEN-1:0]   mul_a_mag, mul_b_mag;
    logic [2*XLEN-1:0] acc_step, mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic [6:0]        last_iter;

    logic              div_special;
    logic              op_illegal;
    logic [XLEN-1:0]   div_special_res;
    logic [XLEN-1:0]   div_res;

    assign in_ready    = (state_q == ST_IDLE);
    assign accept      = in_valid & in_ready & ~flush;
    // Word form only exists for MUL and the divide group
    assign w_in        = is_w & ((op == OP_MUL) | op[2]);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign out_illegal = illegal_q;
    assign last_iter   = w_q ? 7'd31 : 7'd63;

    // Multiplier operand preparation: multiply magnitudes, fix the sign at the end
    always_comb begin
        a_neg_mul = ((op == OP_MULH) | (op == OP_MULHSU)) & alu_a[XLEN-1];
        b_neg_mul = (op == OP_MULH) & alu_b[XLEN-1];
        mul_a_mag = w_in ? {{(XLEN-WLEN){1'b0}}, alu_a[WLEN-1:0]} : cneg(alu_a, a_neg_mul);
        mul_b_mag = w_in ? {{(XLEN-WLEN){1'b0}}, alu_b[WLEN-1:0]} : cneg(alu_b, b_neg_mul);
    end

    // Multiplier step and final result selection from the post-step product
    always_comb begin
        acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mul_prod = neg_q ? (~acc_step + 128'd1) : acc_step;
        if (op_q == OP_MUL) begin
            mul_res = w_q ? sext32(mul_prod[WLEN-1:0]) : mul_prod[XLEN-1:0];
        end else begin
            mul_res = mul_prod[2*XLEN-1:XLEN];
        end
    end

`ifdef ALU_MULDIV_DIV_EN
    logic [XLEN-1:0] rem_q, quot_q, dvsr_q;
    logic            qneg_q, rneg_q;
    logic            d_signed, dvd_neg, dvs_neg, dvs_zero, d_ovf;
    logic [XLEN-1:0] dvd_raw, dvs_raw, dvd_mag, dvs_mag, dvd_ext;
    logic [XLEN-1:0] step_rem, quot_step, q_fin, r_fin, div_pick;
    logic            step_q;

    assign op_illegal = 1'b0;

    // Divider operand decode and the single-cycle boundary cases
    always_comb begin
        d_signed = ~op[0];
        if (w_in) begin
            dvd_raw = d_signed ? sext32(alu_a[WLEN-1:0])
                               : {{(XLEN-WLEN){1'b0}}, alu_a[WLEN-1:0]};
            dvs_raw = d_signed ? sext32(alu_b[WLEN-1:0])
                               : {{(XLEN-WLEN){1'b0}}, alu_b[WLEN-1:0]};
        end else begin
            dvd_raw = alu_a;
            dvs_raw = alu_b;
        end
        dvd_neg  = d_signed & dvd_raw[XLEN-1];
        dvs_neg  = d_signed & dvs_raw[XLEN-1];
        dvd_mag  = cneg(dvd_raw, dvd_neg);
        dvs_mag  = cneg(dvs_raw, dvs_neg);
        dvs_zero = (dvs_raw == '0);
        d_ovf    = d_signed & (dvs_raw == '1) & (dvd_raw == (w_in ? WMIN_EXT : XMIN));
        // Boundary results are sign-extended from 32 bits even for unsigned word ops
        dvd_ext  = w_in ? sext32(alu_a[WLEN-1:0]) : alu_a;
        div_special = op[2] & (dvs_zero | d_ovf);
        if (dvs_zero) begin
            div_special_res = op[1] ? dvd_ext : '1;
        end else begin
            div_special_res = op[1] ? '0 : dvd_ext;
        end
    end

    muldiv_div_step u_div_step (
        .rem_i          (rem_q),
        .dividend_msb_i (quot_q[XLEN-1]),
        .divisor_i      (dvsr_q),
        .rem_o          (step_rem),
        .q_bit_o        (step_q)
    );

    // Divider final result from the post-step quotient/remainder
    always_comb begin
        quot_step = {quot_q[XLEN-2:0], step_q};
        q_fin     = cneg(quot_step, qneg_q);
        r_fin     = cneg(step_rem, rneg_q);
        div_pick  = op_q[1] ? r_fin : q_fin;
        div_res   = w_q ? sext32(div_pick[WLEN-1:0]) : div_pick;
    end

    // Divider registers; word dividends are pre-shifted so the MSB feeds the step
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            rem_q  <= '0;
            quot_q <= w_in ? {dvd_mag[WLEN-1:0], {WLEN{1'b0}}} : dvd_mag;
            dvsr_q <= dvs_mag;
            qneg_q <= dvd_neg ^ dvs_neg;
            rneg_q <= dvd_neg;
        end else if (state_q == ST_CALC) begin
            rem_q  <= step_rem;
            quot_q <= quot_step;
        end
    end
`else
    // No divider: every divide op completes at once as illegal
    assign div_special     = op[2];
    assign div_special_res = '0;
    assign div_res         = '0;
    assign op_illegal      = op[2];
`endif

    // FSM next state, iteration counter and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (div_special) begin
                        state_d   = ST_DONE;
                        result_d  = div_special_res;
                        illegal_d = op_illegal;
                    end else begin
                        state_d   = ST_CALC;
                        illegal_d = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == last_iter) begin
                    state_d  = ST_DONE;
                    cnt_d    = '0;
                    result_d = op_q[2] ? div_res : mul_res;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d   = ST_IDLE;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flush overrides everything and drops any pending result
        if (flush) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            result_d  = '0;
            illegal_d = 1'b0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Request capture and multiplier iteration
    always_ff @(posedge clk) begin
        if (!rstn) begin
            op_q     <= '0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (accept) begin
            op_q     <= op;
            w_q      <= w_in;
            neg_q    <= a_neg_mul ^ b_neg_mul;
            acc_q    <= '0;
            mcand_q  <= {{XLEN{1'b0}}, mul_a_mag};
            mplier_q <= mul_b_mag;
        end else if (state_q == ST_CALC) begin
            acc_q    <= acc_step;
            mcand_q  <= {mcand_q[2*XLEN-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[XLEN-1:1]};
        end
    end

endmodule
